audio_dcfifo: RTL and testbench
===============================

AUDIO_DCFIFO -- requirements
Module: audio_dcfifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the sample word width.
REQ-003 Parameter ADDR_WIDTH, default 15, SHALL set the depth to 2**ADDR_WIDTH words; the audio-to-CPU instances use 16, the CPU-to-audio instances use 15.
REQ-004 Port list:
- system_clk  in  1  clock; all state updates on its rising edge.
- system_reset_n  in  1  async active-low reset.
- data  in  DATA_WIDTH  write word.
- wrreq  in  1  push request.
- rdreq  in  1  pop request (acknowledge of the word on q).
- q  out  DATA_WIDTH  head word, show-ahead.
- rdusedw  out  ADDR_WIDTH  stored word count modulo depth.
- wrusedw  out  ADDR_WIDTH  identical to rdusedw.
- rdempty  out  1  FIFO empty.
- wrempty  out  1  identical to rdempty.
- rdfull  out  1  FIFO full.
- wrfull  out  1  identical to rdfull.

Function
REQ-005 Internal count SHALL be ADDR_WIDTH+1 bits, range 0..2**ADDR_WIDTH.
REQ-006 A write SHALL be accepted when wrreq=1 and full=0 at the clock edge; data goes to mem[wr_ptr], and wr_ptr increments and wraps modulo depth.
REQ-007 wrreq while full SHALL be ignored: no overwrite and no state change.
REQ-008 A read SHALL be accepted when rdreq=1 and empty=0 at the clock edge; rd_ptr increments and wraps modulo depth.
REQ-009 rdreq while empty SHALL be ignored; count SHALL never underflow.
REQ-010 Show-ahead: while empty=0, q SHALL equal mem[rd_ptr] with no read latency; the consumer samples q in the same cycle it asserts rdreq.
REQ-011 While empty=1, q SHALL be 0.
REQ-012 A written word SHALL appear on q, and rdempty SHALL deassert, one clock after the accepting edge.
REQ-013 Simultaneous accepted read and write SHALL leave count unchanged and move both pointers.
REQ-014 When full, rdreq+wrreq together SHALL perform only the read (count-1). When empty, both together SHALL perform only the write (count+1).
REQ-015 empty SHALL equal (count==0) and full SHALL equal (count==2**ADDR_WIDTH); both are derived from registered count with no combinational path from wrreq/rdreq.
REQ-016 rdusedw/wrusedw SHALL equal count[ADDR_WIDTH-1:0], so they read 0 when full; consumers use rdfull to disambiguate full from empty.
REQ-017 Data order SHALL be strictly first-in first-out, with no loss or duplication across pointer wrap-around.

Reset
REQ-018 Asserting system_reset_n low SHALL immediately clear wr_ptr, rd_ptr and count, at any time including mid-transfer.
REQ-019 Reset values: rdempty=wrempty=1, rdfull=wrfull=0, rdusedw=wrusedw=0, q=0.
REQ-020 Memory contents SHALL NOT be reset; stale data SHALL NOT be visible because of REQ-011.
REQ-021 wrreq and rdreq SHALL be ignored while reset is asserted and on the deasserting edge.

Structure
REQ-022 A shared package audio_fifo_pkg SHALL hold the DATA_WIDTH default (16) and the two ADDR_WIDTH defaults (AUDIO_TO_CPU_AW=16, CPU_TO_AUDIO_AW=15).
REQ-023 The block SHALL contain one sub-module, audio_dcfifo_ram: a 2**ADDR_WIDTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port.
REQ-024 Pointer, count and flag logic SHALL live in audio_dcfifo itself.

Verification (bench with ADDR_WIDTH=3, depth 8)
REQ-025 Reset, then idle -> rdempty=1, rdfull=0, rdusedw=0, q=0.
REQ-026 Write 0x1111 then 0x2222 -> one cycle after the first write, q=0x1111 and rdempty=0; after the second, rdusedw=2. Pulse rdreq -> q=0x2222 and rdusedw=1.
REQ-027 Write 8 words 0x0001..0x0008 -> rdfull=1 and rdusedw=0. A ninth write of 0xDEAD is dropped. Read 8 -> sequence 0x0001..0x0008, then rdempty=1 and q=0.
REQ-028 Hold rdreq=1 on an empty FIFO for 3 cycles -> count stays 0, rdempty stays 1, no pointer movement. A subsequent write of 0x00AA reads back 0x00AA.
REQ-029 With count=4, assert wrreq and rdreq together for 20 cycles (incrementing data) -> rdusedw stays 4, pointers wrap, and output order matches input.
REQ-030 With count=5, assert system_reset_n low asynchronously between clock edges -> flags and counts return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/audio_fifo_pkg.sv
// audio_fifo_pkg: width defaults shared by the audio/CPU sample FIFOs.
package audio_fifo_pkg;
   localparam int DATA_WIDTH_DEF  = 16;
   localparam int AUDIO_TO_CPU_AW = 16;
   localparam int CPU_TO_AUDIO_AW = 15;
endpackage

// File: rtl/audio_dcfifo_ram.sv
// audio_dcfifo_ram: register-array storage, synchronous write, asynchronous read.
module audio_dcfifo_ram
   import audio_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = CPU_TO_AUDIO_AW
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/audio_dcfifo.sv
// audio_dcfifo: single-clock show-ahead sample FIFO with pointer/count/flag control.
module audio_dcfifo
   import audio_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = CPU_TO_AUDIO_AW
) (
   input  logic                  system_clk,
   input  logic                  system_reset_n,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  wrreq,
   input  logic                  rdreq,
   output logic [DATA_WIDTH-1:0] q,
   output logic [ADDR_WIDTH-1:0] rdusedw,
   output logic [ADDR_WIDTH-1:0] wrusedw,
   output logic                  rdempty,
   output logic                  wrempty,
   output logic                  rdfull,
   output logic                  wrfull
);
   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic [DATA_WIDTH-1:0] head;
   logic                  empty, full, wr_en, rd_en;
   assign empty = count == '0;
   assign full  = count == DEPTH;
   assign wr_en = wrreq && !full;
   assign rd_en = rdreq && !empty;
   audio_dcfifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (system_clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (data),
      .raddr (rd_ptr),
      .rdata (head)
   );
   always_ff @(posedge system_clk or negedge system_reset_n)
      if (!system_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en != rd_en) count <= wr_en ? count + 1'b1 : count - 1'b1;
      end
   // Memory is never cleared, so stale words are masked while empty.
   assign q       = empty ? '0 : head;
   assign rdusedw = count[ADDR_WIDTH-1:0];
   assign wrusedw = count[ADDR_WIDTH-1:0];
   assign rdempty = empty;
   assign wrempty = empty;
   assign rdfull  = full;
   assign wrfull  = full;
endmodule

// File: tb/tb_audio_dcfifo.sv
// tb_audio_dcfifo: randomized and directed checks of audio_dcfifo against a queue model.
module tb_audio_dcfifo;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   logic        clk = 0, rst_n = 0, wrreq = 0, rdreq = 0;
   logic [15:0] data = '0, q;
   logic [AW-1:0] rdusedw, wrusedw;
   logic        rdempty, wrempty, rdfull, wrfull;
   int          errors = 0, checks = 0;
   logic [15:0] model[$];

   audio_dcfifo #(.DATA_WIDTH(16), .ADDR_WIDTH(AW)) dut (
      .system_clk(clk), .system_reset_n(rst_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
      .q(q), .rdusedw(rdusedw), .wrusedw(wrusedw), .rdempty(rdempty), .wrempty(wrempty),
      .rdfull(rdfull), .wrfull(wrfull)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      bit r, w;
      @(posedge clk);
      r = rdreq && model.size() > 0;
      w = wrreq && model.size() < DEPTH;
      if (r) void'(model.pop_front());
      if (w) model.push_back(data);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      data = d; wrreq = 1; cycle(); wrreq = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; wrreq = 1; rdreq = 1; data = 16'hBEEF;
      repeat (2) @(posedge clk);
      #1 rst_n = 1; wrreq = 0; rdreq = 0;
      model.delete();
      cycle();
      checks += 7;
      if (rdempty !== 1'b1) begin errors++; $display("FAIL reset_rdempty: got %b want 1", rdempty); end
      if (wrempty !== 1'b1) begin errors++; $display("FAIL reset_wrempty: got %b want 1", wrempty); end
      if (rdfull !== 1'b0) begin errors++; $display("FAIL reset_rdfull: got %b want 0", rdfull); end
      if (wrfull !== 1'b0) begin errors++; $display("FAIL reset_wrfull: got %b want 0", wrfull); end
      if (rdusedw !== 3'd0) begin errors++; $display("FAIL reset_rdusedw: got %0d want 0", rdusedw); end
      if (wrusedw !== 3'd0) begin errors++; $display("FAIL reset_wrusedw: got %0d want 0", wrusedw); end
      if (q !== 16'h0) begin errors++; $display("FAIL reset_q: got %h want 0000", q); end
   endtask

   task automatic test_basic();
      push(16'h1111);
      checks += 2;
      if (q !== 16'h1111) begin errors++; $display("FAIL basic_q_first: got %h want 1111", q); end
      if (rdempty !== 1'b0) begin errors++; $display("FAIL basic_rdempty: got %b want 0", rdempty); end
      push(16'h2222);
      checks++;
      if (rdusedw !== 3'd2) begin errors++; $display("FAIL basic_usedw2: got %0d want 2", rdusedw); end
      rdreq = 1; cycle(); rdreq = 0;
      checks += 2;
      if (q !== 16'h2222) begin errors++; $display("FAIL basic_q_second: got %h want 2222", q); end
      if (rdusedw !== 3'd1) begin errors++; $display("FAIL basic_usedw1: got %0d want 1", rdusedw); end
      rdreq = 1; cycle(); rdreq = 0;
   endtask

   task automatic test_full();
      for (int i = 1; i <= 8; i++) push(16'(i));
      checks += 3;
      if (rdfull !== 1'b1) begin errors++; $display("FAIL full_rdfull: got %b want 1", rdfull); end
      if (wrfull !== 1'b1) begin errors++; $display("FAIL full_wrfull: got %b want 1", wrfull); end
      if (rdusedw !== 3'd0) begin errors++; $display("FAIL full_usedw: got %0d want 0", rdusedw); end
      push(16'hDEAD);
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (q !== 16'(i)) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, q, 16'(i)); end
         rdreq = 1; cycle(); rdreq = 0;
      end
      checks += 2;
      if (rdempty !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got %b want 1", rdempty); end
      if (q !== 16'h0) begin errors++; $display("FAIL full_drain_q: got %h want 0000", q); end
   endtask

   task automatic test_empty_read();
      rdreq = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks += 2;
         if (rdempty !== 1'b1) begin errors++; $display("FAIL underflow_empty[%0d]: got %b want 1", i, rdempty); end
         if (rdusedw !== 3'd0) begin errors++; $display("FAIL underflow_usedw[%0d]: got %0d want 0", i, rdusedw); end
      end
      rdreq = 0;
      push(16'h00AA);
      checks += 2;
      if (q !== 16'h00AA) begin errors++; $display("FAIL underflow_readback: got %h want 00aa", q); end
      if (rdusedw !== 3'd1) begin errors++; $display("FAIL underflow_usedw_after: got %0d want 1", rdusedw); end
      rdreq = 1; cycle(); rdreq = 0;
   endtask

   task automatic test_back_to_back();
      int k = 0;
      for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i));
      wrreq = 1; rdreq = 1;
      for (int i = 0; i < 20; i++) begin
         data = 16'h0200 + 16'(i);
         checks++;
         if (q !== (k < 4 ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k - 4)))
            begin errors++; $display("FAIL b2b_order[%0d]: got %h", k, q); end
         k++;
         cycle();
         checks++;
         if (rdusedw !== 3'd4) begin errors++; $display("FAIL b2b_usedw[%0d]: got %0d want 4", i, rdusedw); end
      end
      wrreq = 0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q !== 16'h0200 + 16'(k - 4)) begin errors++; $display("FAIL b2b_drain[%0d]: got %h want %h", k, q, 16'h0200 + 16'(k - 4)); end
         k++;
         cycle();
      end
      rdreq = 0;
      checks++;
      if (rdempty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", rdempty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) push(16'h0500 + 16'(i));
      checks++;
      if (rdusedw !== 3'd5) begin errors++; $display("FAIL areset_pre_usedw: got %0d want 5", rdusedw); end
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      model.delete();
      checks += 4;
      if (rdempty !== 1'b1) begin errors++; $display("FAIL areset_empty: got %b want 1", rdempty); end
      if (rdfull !== 1'b0) begin errors++; $display("FAIL areset_full: got %b want 0", rdfull); end
      if (rdusedw !== 3'd0) begin errors++; $display("FAIL areset_usedw: got %0d want 0", rdusedw); end
      if (q !== 16'h0) begin errors++; $display("FAIL areset_q: got %h want 0000", q); end
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wrreq = $urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 75 : 25);
         rdreq = $urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 25 : 75);
         data = 16'($urandom);
         cycle();
         checks += 4;
         if (q !== (model.size() > 0 ? model[0] : 16'h0))
            begin errors++; $display("FAIL rand_q[%0d]: got %h want %h", i, q, model.size() > 0 ? model[0] : 16'h0); end
         if (rdusedw !== 3'(model.size() % DEPTH))
            begin errors++; $display("FAIL rand_usedw[%0d]: got %0d want %0d", i, rdusedw, model.size() % DEPTH); end
         if (rdempty !== (model.size() == 0))
            begin errors++; $display("FAIL rand_empty[%0d]: got %b want %b", i, rdempty, model.size() == 0); end
         if (rdfull !== (model.size() == DEPTH))
            begin errors++; $display("FAIL rand_full[%0d]: got %b want %b", i, rdfull, model.size() == DEPTH); end
      end
      wrreq = 0; rdreq = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_empty_read();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
